ip2_test3_dut_emu: RTL and testbench
====================================

# ip2_test3_dut_emu

Cycle-accurate emulator of the CMS pix28 IP2 DUT's DNN output pair, used for firmware loopback without the ASIC. It consumes the test-3 stimulus (DUT reset_not and vin_test_trig_out) and, after a programmable latency, drives configurable serial bit patterns on dnn_output_0/1. The capturing state machine can then be checked against known data. It sits in the 400 MHz fabric domain in place of the ASIC pins, selected by the loopback mux.

## Interface
Parameters:
- PATTERN_W, 16, length in bits of each emitted serial burst
- CNT_W, 8, width of the burst and overrun counters

Ports:
- clk  in  1  400 MHz fabric clock (pl_clk1)
- reset  in  1  asynchronous, active-high; clears all state, counters and outputs
- enable  in  1  synchronous; low forces IDLE and zero outputs; counters are held
- dut_reset_not  in  1  DUT reset, active low; treated as asynchronous to clk
- dut_vin_test_trig_out  in  1  DUT trigger; treated as asynchronous to clk
- cfg_latency  in  6  cycles from detected trigger edge to first pattern bit
- cfg_pattern_0  in  PATTERN_W  bits emitted on dnn_output_0, MSB first
- cfg_pattern_1  in  PATTERN_W  bits emitted on dnn_output_1, MSB first
- cfg_hold  in  1  1 = hold last bit after burst until trigger falls; 0 = return to 0
- dnn_output_0  out  1  emulated DNN output 0, registered
- dnn_output_1  out  1  emulated DNN output 1, registered
- emu_state  out  3  current state encoding, for debug
- emu_busy  out  1  high in WAIT, SHIFT and TAIL
- emu_burst_count  out  CNT_W  number of completed bursts; wraps modulo 2^CNT_W
- emu_overrun_count  out  CNT_W  trigger rising edges seen outside ARMED; saturates at all-ones

## Operation
- Input conditioning:
  - dut_reset_not and dut_vin_test_trig_out each pass through a 2-flop synchronizer, giving rn_s and trig_s.
  - trig_re = trig_s & ~trig_s_d, where trig_s_d is trig_s delayed one cycle.
  - trig_fe is the falling-edge equivalent.
- States: IDLE, ARMED, WAIT, SHIFT, TAIL.
- IDLE:
  - Outputs are 0.
  - Moves to ARMED when enable=1 and rn_s=1.
- ARMED:
  - Outputs are 0.
  - On trig_re, latch cfg_pattern_0/1, cfg_latency and cfg_hold into shadow registers.
  - Go to WAIT if the latched latency is nonzero, otherwise go to SHIFT.
- WAIT:
  - Down-counts the latched latency.
  - Goes to SHIFT when the count reaches 1.
- SHIFT:
  - Drives shadow bit [PATTERN_W-1-i] on the outputs for i = 0..PATTERN_W-1, one bit per cycle.
  - After the last bit: increment emu_burst_count, then go to TAIL.
- TAIL:
  - Outputs hold bit 0 if the shadow cfg_hold=1, else 0.
  - Goes to ARMED when trig_s=0 (falling edge or already low); outputs go to 0 on that transition.
- Priority, highest first:
  1. reset
  2. enable=0
  3. rn_s=0
  4. normal transitions
- rn_s=0 in any state: go to IDLE at the next edge and clear the outputs. The burst is aborted and not counted.
- Overrun: trig_re while in WAIT, SHIFT or TAIL increments emu_overrun_count. The burst in progress is unaffected.
- trig_re while in IDLE is ignored and not counted.
- cfg_* changes mid-burst have no effect; only the shadow copies are used.

## Timing
- Reset values: all outputs 0, emu_state=IDLE, both counters 0, synchronizer flops 0.
- Let E0 be the first clk edge that samples dut_vin_test_trig_out high. Then trig_s is high after E1 and trig_re is seen at E2.
- First pattern bit appears on the outputs after edge E2+max(cfg_latency,1). Latency 0 and latency 1 are therefore equal: bit 15 is valid after E3.
- Bits are valid for exactly one cycle each, with consecutive bits on consecutive cycles.
- emu_burst_count increments on the edge that leaves SHIFT.
- rn_s low reaches IDLE 3 edges after dut_reset_not falls (2 synchronizer edges plus 1 state edge).
- After dut_reset_not returns high: 2 synchronizer edges, then ARMED on the next edge.
- A trigger pulse shorter than 2 clk cycles may be missed; this is allowed.

## Test plan
- Basic burst:
  - Stimulus: pattern_0=16'hA5C3, pattern_1=16'h0FF0, latency=4, hold=0; raise trig at E0 and hold for 40 cycles.
  - Response: dnn_output_0 = 1010_0101_1100_0011, starting after E6; dnn_output_1 likewise; 0 afterwards; burst_count=1.
- Hold mode:
  - Stimulus: pattern_0=16'h0001, hold=1.
  - Response: dnn_output_0 stays 1 after the burst until 2 edges after trig falls, then 0; ARMED again.
- Latency 0 vs 1:
  - Stimulus: one burst with latency 0 and one with latency 1.
  - Response: identical first-bit timing, bit 15 valid after E3.
- Reset abort:
  - Stimulus: pull dut_reset_not low during bit 5 of SHIFT.
  - Response: outputs 0 within 3 edges; state IDLE; burst_count unchanged.
  - Then release dut_reset_not and retrigger: a full burst is emitted.
- Overrun:
  - Stimulus: pulse trig twice within one burst (the second rising edge lands in SHIFT).
  - Response: overrun_count=1, burst output uncorrupted.
  - Also: 300 overruns give overrun_count=255.
- Async reset and enable:
  - Stimulus: assert reset mid-SHIFT.
  - Response: outputs and counters go 0 immediately, without a clock edge.
  - Stimulus: drop enable mid-burst.
  - Response: IDLE, outputs 0, counters keep their values.

Source files
------------

// File: rtl/ip2_test3_dut_emu_if.sv
// Pin bundle between the loopback mux / register block and the pix28 IP2 DNN-output emulator.
// master drives stimulus and configuration; slave (the emulator) returns the serial outputs and status.
`timescale 1ns/1ps
interface ip2_test3_dut_emu_if #(
    parameter int PATTERN_W = 16,
    parameter int CNT_W     = 8
);
    logic                 enable;
    logic                 dut_reset_not;
    logic                 dut_vin_test_trig_out;
    logic [5:0]           cfg_latency;
    logic [PATTERN_W-1:0] cfg_pattern_0;
    logic [PATTERN_W-1:0] cfg_pattern_1;
    logic                 cfg_hold;
    logic                 dnn_output_0;
    logic                 dnn_output_1;
    logic [2:0]           emu_state;
    logic                 emu_busy;
    logic [CNT_W-1:0]     emu_burst_count;
    logic [CNT_W-1:0]     emu_overrun_count;

    modport master (
        output enable, dut_reset_not, dut_vin_test_trig_out,
        output cfg_latency, cfg_pattern_0, cfg_pattern_1, cfg_hold,
        input  dnn_output_0, dnn_output_1, emu_state, emu_busy,
        input  emu_burst_count, emu_overrun_count
    );

    modport slave (
        input  enable, dut_reset_not, dut_vin_test_trig_out,
        input  cfg_latency, cfg_pattern_0, cfg_pattern_1, cfg_hold,
        output dnn_output_0, dnn_output_1, emu_state, emu_busy,
        output emu_burst_count, emu_overrun_count
    );
endinterface

// File: rtl/ip2_test3_dut_emu.sv
// Emulates the IP2 DUT DNN output pair: on a synchronized trigger edge, waits max(latency,1) cycles
// then shifts two PATTERN_W-bit bursts MSB first; no backpressure, the outputs are free-running pins.
`timescale 1ns/1ps
module ip2_test3_dut_emu #(
    parameter int PATTERN_W = 16,
    parameter int CNT_W     = 8
) (
    input  logic               clk,
    input  logic               reset,
    ip2_test3_dut_emu_if.slave bus
);
    localparam int IDX_W = $clog2(PATTERN_W + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_WAIT  = 3'd2,
        S_SHIFT = 3'd3,
        S_TAIL  = 3'd4
    } state_t;

    state_t               r_state;
    logic [1:0]           r_rn_sync;
    logic [1:0]           r_trig_sync;
    logic                 r_trig_d;
    logic [PATTERN_W-1:0] r_sh_0;
    logic [PATTERN_W-1:0] r_sh_1;
    logic                 r_hold;
    logic [5:0]           r_wait_cnt;
    logic [IDX_W-1:0]     r_bit_cnt;
    logic                 r_dnn_0;
    logic                 r_dnn_1;
    logic [CNT_W-1:0]     r_burst_cnt;
    logic [CNT_W-1:0]     r_ovr_cnt;

    state_t               w_state_nxt;
    logic [PATTERN_W-1:0] w_sh_0_nxt;
    logic [PATTERN_W-1:0] w_sh_1_nxt;
    logic                 w_hold_nxt;
    logic [5:0]           w_wait_cnt_nxt;
    logic [IDX_W-1:0]     w_bit_cnt_nxt;
    logic                 w_dnn_0_nxt;
    logic                 w_dnn_1_nxt;
    logic [CNT_W-1:0]     w_burst_cnt_nxt;
    logic [CNT_W-1:0]     w_ovr_cnt_nxt;

    logic                 w_rn_s;
    logic                 w_trig_s;
    logic                 w_trig_re;
    logic                 w_busy;

    assign w_rn_s    = r_rn_sync[1];
    assign w_trig_s  = r_trig_sync[1];
    assign w_trig_re = w_trig_s & ~r_trig_d;
    assign w_busy    = (r_state == S_WAIT) || (r_state == S_SHIFT) || (r_state == S_TAIL);

    // Both DUT pins come from another clock domain; two flops each before any use.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rn_sync   <= 2'b00;
            r_trig_sync <= 2'b00;
            r_trig_d    <= 1'b0;
        end else begin
            r_rn_sync   <= {r_rn_sync[0], bus.dut_reset_not};
            r_trig_sync <= {r_trig_sync[0], bus.dut_vin_test_trig_out};
            r_trig_d    <= r_trig_sync[1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_sh_0      <= '0;
            r_sh_1      <= '0;
            r_hold      <= 1'b0;
            r_wait_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_dnn_0     <= 1'b0;
            r_dnn_1     <= 1'b0;
            r_burst_cnt <= '0;
            r_ovr_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_sh_0      <= w_sh_0_nxt;
            r_sh_1      <= w_sh_1_nxt;
            r_hold      <= w_hold_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_dnn_0     <= w_dnn_0_nxt;
            r_dnn_1     <= w_dnn_1_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
            r_ovr_cnt   <= w_ovr_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_sh_0_nxt      = r_sh_0;
        w_sh_1_nxt      = r_sh_1;
        w_hold_nxt      = r_hold;
        w_wait_cnt_nxt  = r_wait_cnt;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_dnn_0_nxt     = 1'b0;
        w_dnn_1_nxt     = 1'b0;
        w_burst_cnt_nxt = r_burst_cnt;
        w_ovr_cnt_nxt   = r_ovr_cnt;

        if (!bus.enable || !w_rn_s) begin
            w_state_nxt = S_IDLE;
        end else begin
            if (w_trig_re && w_busy && (r_ovr_cnt != {CNT_W{1'b1}})) begin
                w_ovr_cnt_nxt = r_ovr_cnt + CNT_W'(1);
            end

            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_ARMED;
                end
                S_ARMED: begin
                    if (w_trig_re) begin
                        w_sh_0_nxt     = bus.cfg_pattern_0;
                        w_sh_1_nxt     = bus.cfg_pattern_1;
                        w_hold_nxt     = bus.cfg_hold;
                        w_wait_cnt_nxt = bus.cfg_latency;
                        w_bit_cnt_nxt  = '0;
                        w_state_nxt    = (bus.cfg_latency != 6'd0) ? S_WAIT : S_SHIFT;
                    end
                end
                S_WAIT: begin
                    // The WAIT->SHIFT edge already drives the MSB, so latency 1 and 0 line up.
                    if (r_wait_cnt <= 6'd1) begin
                        w_dnn_0_nxt   = r_sh_0[PATTERN_W-1];
                        w_dnn_1_nxt   = r_sh_1[PATTERN_W-1];
                        w_sh_0_nxt    = r_sh_0 << 1;
                        w_sh_1_nxt    = r_sh_1 << 1;
                        w_bit_cnt_nxt = IDX_W'(1);
                        w_state_nxt   = S_SHIFT;
                    end else begin
                        w_wait_cnt_nxt = r_wait_cnt - 6'd1;
                    end
                end
                S_SHIFT: begin
                    if (r_bit_cnt == IDX_W'(PATTERN_W)) begin
                        w_dnn_0_nxt     = r_hold & r_dnn_0;
                        w_dnn_1_nxt     = r_hold & r_dnn_1;
                        w_burst_cnt_nxt = r_burst_cnt + CNT_W'(1);
                        w_state_nxt     = S_TAIL;
                    end else begin
                        w_dnn_0_nxt   = r_sh_0[PATTERN_W-1];
                        w_dnn_1_nxt   = r_sh_1[PATTERN_W-1];
                        w_sh_0_nxt    = r_sh_0 << 1;
                        w_sh_1_nxt    = r_sh_1 << 1;
                        w_bit_cnt_nxt = r_bit_cnt + IDX_W'(1);
                    end
                end
                S_TAIL: begin
                    // r_dnn_* still carries pattern bit 0 here when hold is set.
                    if (!w_trig_s) begin
                        w_state_nxt = S_ARMED;
                    end else begin
                        w_dnn_0_nxt = r_hold & r_dnn_0;
                        w_dnn_1_nxt = r_hold & r_dnn_1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign bus.dnn_output_0      = r_dnn_0;
    assign bus.dnn_output_1      = r_dnn_1;
    assign bus.emu_state         = r_state;
    assign bus.emu_busy          = w_busy;
    assign bus.emu_burst_count   = r_burst_cnt;
    assign bus.emu_overrun_count = r_ovr_cnt;
endmodule

// File: tb/tb_ip2_test3_dut_emu.sv
// Directed bench for the IP2 DNN-output emulator: burst timing, hold, latency 0/1, aborts, overruns.
`timescale 1ns/1ps
module tb_ip2_test3_dut_emu;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   exp_burst;

    ip2_test3_dut_emu_if #(.PATTERN_W(16), .CNT_W(8)) bus ();

    ip2_test3_dut_emu #(.PATTERN_W(16), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] outs();
        return {30'd0, bus.dnn_output_1, bus.dnn_output_0};
    endfunction

    // Raise trigger, check silence just before the first bit, then all 16 bits; cfg is scrambled
    // once the shadow copy is taken. Returns one edge after the last bit (state TAIL).
    task automatic fire(input string tag, input logic [15:0] p0, input logic [15:0] p1,
                        input logic [5:0] lat, input logic hold, input bit pulse);
        int m;
        m = (lat == 6'd0) ? 1 : int'(lat);
        bus.cfg_pattern_0 = p0;
        bus.cfg_pattern_1 = p1;
        bus.cfg_latency   = lat;
        bus.cfg_hold      = hold;
        bus.dut_vin_test_trig_out = 1'b1;
        repeat (m + 2) tick();
        check($sformatf("%s_pre", tag), outs(), 32'd0);
        bus.cfg_pattern_0 = ~p0;
        bus.cfg_pattern_1 = ~p1;
        bus.cfg_latency   = 6'd63;
        bus.cfg_hold      = ~hold;
        for (int i = 15; i >= 0; i--) begin
            tick();
            check($sformatf("%s_b%0d", tag, i), outs(), {30'd0, p1[i], p0[i]});
            if (pulse && i == 12) bus.dut_vin_test_trig_out = 1'b0;
            if (pulse && i == 8)  bus.dut_vin_test_trig_out = 1'b1;
        end
        tick();
    endtask

    task automatic drop_trig(input string tag);
        bus.dut_vin_test_trig_out = 1'b0;
        repeat (3) tick();
        check($sformatf("%s_rearm", tag), 32'(bus.emu_state), 32'd1);
        check($sformatf("%s_idle_out", tag), outs(), 32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        exp_burst = 0;
        reset = 1'b1;
        bus.enable = 1'b0;
        bus.dut_reset_not = 1'b0;
        bus.dut_vin_test_trig_out = 1'b0;
        bus.cfg_latency = 6'd0;
        bus.cfg_pattern_0 = 16'h0;
        bus.cfg_pattern_1 = 16'h0;
        bus.cfg_hold = 1'b0;
        repeat (2) tick();
        check("rst_out",   outs(), 32'd0);
        check("rst_state", 32'(bus.emu_state), 32'd0);
        check("rst_burst", 32'(bus.emu_burst_count), 32'd0);
        check("rst_ovr",   32'(bus.emu_overrun_count), 32'd0);
        check("rst_busy",  32'(bus.emu_busy), 32'd0);

        reset = 1'b0;
        bus.enable = 1'b1;
        bus.dut_reset_not = 1'b1;
        repeat (2) tick();
        check("arm_sync_wait", 32'(bus.emu_state), 32'd0);
        tick();
        check("arm_state", 32'(bus.emu_state), 32'd1);

        // Basic burst, latency 4: first bit after E6.
        fire("basic", 16'hA5C3, 16'h0FF0, 6'd4, 1'b0, 1'b0);
        exp_burst++;
        check("basic_tail_out", outs(), 32'd0);
        check("basic_tail_st",  32'(bus.emu_state), 32'd4);
        check("basic_busy",     32'(bus.emu_busy), 32'd1);
        check("basic_burst",    32'(bus.emu_burst_count), 32'(exp_burst));
        repeat (17) tick();
        check("basic_tail_quiet", outs(), 32'd0);
        drop_trig("basic");
        check("basic_idle_busy", 32'(bus.emu_busy), 32'd0);

        // Hold mode: bit 0 persists until the trigger has been low for two edges.
        fire("hold", 16'h0001, 16'h8000, 6'd2, 1'b1, 1'b0);
        exp_burst++;
        check("hold_tail0", outs(), 32'd1);
        repeat (3) tick();
        check("hold_tail3", outs(), 32'd1);
        bus.dut_vin_test_trig_out = 1'b0;
        repeat (2) tick();
        check("hold_fall2", outs(), 32'd1);
        tick();
        check("hold_fall3", outs(), 32'd0);
        check("hold_armed", 32'(bus.emu_state), 32'd1);
        check("hold_burst", 32'(bus.emu_burst_count), 32'(exp_burst));

        // Latency 0 and 1 both give bit 15 after E3.
        fire("lat0", 16'hC3A5, 16'h5A3C, 6'd0, 1'b0, 1'b0);
        exp_burst++;
        drop_trig("lat0");
        fire("lat1", 16'hC3A5, 16'h5A3C, 6'd1, 1'b0, 1'b0);
        exp_burst++;
        check("lat1_burst", 32'(bus.emu_burst_count), 32'(exp_burst));
        drop_trig("lat1");

        // Reset abort in the middle of SHIFT.
        bus.cfg_pattern_0 = 16'hFFFF;
        bus.cfg_pattern_1 = 16'hFFFF;
        bus.cfg_latency = 6'd1;
        bus.cfg_hold = 1'b0;
        bus.dut_vin_test_trig_out = 1'b1;
        repeat (4) tick();
        check("abort_first", outs(), 32'd3);
        repeat (5) tick();
        bus.dut_reset_not = 1'b0;
        bus.dut_vin_test_trig_out = 1'b0;
        repeat (2) tick();
        check("abort_sync", outs(), 32'd3);
        tick();
        check("abort_out",   outs(), 32'd0);
        check("abort_state", 32'(bus.emu_state), 32'd0);
        check("abort_burst", 32'(bus.emu_burst_count), 32'(exp_burst));
        bus.dut_reset_not = 1'b1;
        repeat (2) tick();
        check("abort_rel2", 32'(bus.emu_state), 32'd0);
        tick();
        check("abort_rel3", 32'(bus.emu_state), 32'd1);
        fire("rearm", 16'h9BDF, 16'h6420, 6'd5, 1'b0, 1'b0);
        exp_burst++;
        check("rearm_burst", 32'(bus.emu_burst_count), 32'(exp_burst));
        drop_trig("rearm");

        // Second trigger edge inside SHIFT.
        fire("ovr", 16'h1234, 16'hFEDC, 6'd3, 1'b0, 1'b1);
        exp_burst++;
        check("ovr_count", 32'(bus.emu_overrun_count), 32'd1);
        check("ovr_burst", 32'(bus.emu_burst_count), 32'(exp_burst));
        drop_trig("ovr");

        // Enable drop mid-burst.
        bus.cfg_pattern_0 = 16'hFFFF;
        bus.cfg_pattern_1 = 16'hFFFF;
        bus.cfg_latency = 6'd1;
        bus.dut_vin_test_trig_out = 1'b1;
        repeat (6) tick();
        bus.enable = 1'b0;
        tick();
        check("en_state", 32'(bus.emu_state), 32'd0);
        check("en_out",   outs(), 32'd0);
        check("en_burst", 32'(bus.emu_burst_count), 32'(exp_burst));
        check("en_ovr",   32'(bus.emu_overrun_count), 32'd1);
        bus.enable = 1'b1;
        bus.dut_vin_test_trig_out = 1'b0;
        repeat (3) tick();
        check("en_rearm", 32'(bus.emu_state), 32'd1);

        // Saturation: several hundred rising edges land in busy states.
        bus.cfg_latency = 6'd63;
        for (int k = 0; k < 500; k++) begin
            bus.dut_vin_test_trig_out = 1'b1;
            repeat (2) tick();
            bus.dut_vin_test_trig_out = 1'b0;
            repeat (2) tick();
        end
        repeat (100) tick();
        check("sat_ovr",   32'(bus.emu_overrun_count), 32'd255);
        check("sat_state", 32'(bus.emu_state), 32'd1);

        // Asynchronous reset mid-SHIFT, checked before any clock edge.
        bus.cfg_pattern_0 = 16'hFFFF;
        bus.cfg_pattern_1 = 16'hFFFF;
        bus.cfg_latency = 6'd1;
        bus.dut_vin_test_trig_out = 1'b1;
        repeat (6) tick();
        check("arst_pre", outs(), 32'd3);
        reset = 1'b1;
        #1;
        check("arst_out",   outs(), 32'd0);
        check("arst_state", 32'(bus.emu_state), 32'd0);
        check("arst_burst", 32'(bus.emu_burst_count), 32'd0);
        check("arst_ovr",   32'(bus.emu_overrun_count), 32'd0);
        tick();
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
